mem_lsu: RTL

//  Load/store unit between the core's execute stage and mem_data (32b word RAM, 1-cycle registered read,

---
 rtl/mem_lsu_pkg.sv | 35 +++
 rtl/mem_lsu_align.sv | 51 +++++
 rtl/mem_lsu.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_pkg
// Description : Shared types, funct3 codes and alignment helper for mem_lsu.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_DATA = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = |addr_lo;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_align
// Description : Byte/half lane extraction with extension, and store-lane merge.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_val,
    output logic [31:0] o_merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_byte_sh;

    always_comb begin
        w_byte_sh = {i_addr_lo, 3'b000};
        w_byte    = i_old_word[w_byte_sh +: 8];
        w_half    = i_addr_lo[1] ? i_old_word[31:16] : i_old_word[15:0];

        case (i_funct3)
            F3_B:    o_load_val = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_val = {{16{w_half[15]}}, w_half};
            F3_BU:   o_load_val = {24'd0, w_byte};
            F3_HU:   o_load_val = {16'd0, w_half};
            default: o_load_val = i_old_word;
        endcase

        // Size code alone selects the lane width; only SB/SH ever reach the merge.
        o_merged_word = i_old_word;
        case (i_funct3[1:0])
            2'b00: o_merged_word[w_byte_sh +: 8] = i_store_data[7:0];
            2'b01: begin
                if (i_addr_lo[1]) begin
                    o_merged_word[31:16] = i_store_data[15:0];
                end else begin
                    o_merged_word[15:0] = i_store_data[15:0];
                end
            end
            default: o_merged_word = i_store_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : RV32 load/store unit converting byte/half/word accesses into
//               word reads, read-modify-writes and word writes on mem_data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int WORD_ADDR_BITS = 9
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] mem_addr_r_o,
    input  logic [31:0] mem_data_r_i,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_w_o,
    output logic [31:0] mem_data_w_o
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_merged;
    logic [31:0] r_rd_addr;

    logic        w_accept;
    logic        w_bad_f3;
    logic        w_range_err;
    logic        w_req_err;
    logic [31:0] w_word_addr;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;

    assign w_accept    = req_i && ready_o;
    assign w_bad_f3    = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    assign w_range_err = |addr_i[31:WORD_ADDR_BITS+2];
    assign w_req_err   = w_bad_f3 || w_range_err || (we_i && funct3_i[2])
                       || is_misaligned(funct3_i, addr_i[1:0]);
    assign w_word_addr = {r_addr[31:2], 2'b00};

    mem_lsu_align u_align (
        .i_funct3      (r_funct3),
        .i_addr_lo     (r_addr[1:0]),
        .i_old_word    (mem_data_r_i),
        .i_store_data  (r_wdata),
        .o_load_val    (w_load_val),
        .o_merged_word (w_merged)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_state_nxt = ST_FIN;
                    end else if (we_i && (funct3_i == F3_W)) begin
                        w_state_nxt = ST_WR;
                    end else begin
                        w_state_nxt = ST_RD;
                    end
                end
            end
            ST_RD:   w_state_nxt = ST_DATA;
            ST_DATA: w_state_nxt = r_we ? ST_WR : ST_FIN;
            ST_WR:   w_state_nxt = ST_FIN;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_o      = (r_state == ST_IDLE);
        done_o       = (r_state == ST_FIN);
        err_o        = (r_state == ST_FIN) && r_err;
        mem_wr_en_o  = (r_state == ST_WR);
        mem_addr_r_o = (r_state == ST_RD) ? w_word_addr : r_rd_addr;
        mem_addr_w_o = w_word_addr;
        mem_data_w_o = (r_funct3 == F3_W) ? r_wdata : r_merged;
        rdata_o      = r_rdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
            r_merged  <= 32'd0;
            r_rd_addr <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we     <= we_i;
                r_funct3 <= funct3_i;
                r_addr   <= addr_i;
                r_wdata  <= wdata_i;
                r_err    <= w_req_err;
            end
            if (r_state == ST_RD) begin
                r_rd_addr <= w_word_addr;
            end
            // The read word is only valid in DATA; loads retire it, stores merge it.
            if (r_state == ST_DATA) begin
                if (r_we) begin
                    r_merged <= w_merged;
                end else begin
                    r_rdata <= w_load_val;
                end
            end
        end
    end

endmodule
`default_nettype wire
